// File: rtl/data_mem_arbiter_pkg.sv
// Shared widths, grant-select encoding and the byte-lane helper for the data memory arbiter.
package data_mem_arbiter_pkg;

    localparam int CPU_WIDTH = 32;
    localparam int BE_W      = 4;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_M0   = 2'd1,
        SEL_M1   = 2'd2
    } sel_e;

    function automatic logic [7:0] lane_pick(input logic take_new,
                                             input logic [7:0] new_b,
                                             input logic [7:0] old_b);
        lane_pick = take_new ? new_b : old_b;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_be_merge.sv
// Combinational byte-lane merge: enabled lanes take the store data, the rest keep the old word.
module data_mem_arbiter_be_merge
    import data_mem_arbiter_pkg::*;
#(
    parameter int DW = CPU_WIDTH
) (
    input  logic [DW-1:0]   old_i,
    input  logic [DW-1:0]   new_i,
    input  logic [BE_W-1:0] be_i,
    output logic [DW-1:0]   merged_o
);

    // Lane-by-lane select between the current memory word and the store data.
    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < BE_W; i++) begin
            merged_o[8*i +: 8] = lane_pick(be_i[i], new_i[8*i +: 8], old_i[8*i +: 8]);
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter for the single-port data memory: m0 has priority, m1 is starvation-protected,
// sub-word stores are merged read-modify-write in one cycle, responses are registered.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int DW           = CPU_WIDTH,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req_i,
    input  logic            m0_we_i,
    input  logic [DW-1:0]   m0_addr_i,
    input  logic [DW-1:0]   m0_wdata_i,
    input  logic [BE_W-1:0] m0_be_i,
    output logic            m0_gnt_o,
    output logic            m0_rvalid_o,
    output logic [DW-1:0]   m0_rdata_o,

    input  logic            m1_req_i,
    input  logic            m1_we_i,
    input  logic [DW-1:0]   m1_addr_i,
    input  logic [DW-1:0]   m1_wdata_i,
    input  logic [BE_W-1:0] m1_be_i,
    output logic            m1_gnt_o,
    output logic            m1_rvalid_o,
    output logic [DW-1:0]   m1_rdata_o,

    output logic [DW-1:0]   mem_addr_o,
    output logic            mem_wr_en_o,
    output logic [DW-1:0]   mem_data_o,
    input  logic [DW-1:0]   mem_data_i
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    sel_e             sel_s;
    logic             sel_we_s;
    logic [DW-1:0]    sel_wdata_s;
    logic [BE_W-1:0]  sel_be_s;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             m0_rvalid_q, m0_rvalid_d;
    logic             m1_rvalid_q, m1_rvalid_d;
    logic [DW-1:0]    m0_rdata_q, m0_rdata_d;
    logic [DW-1:0]    m1_rdata_q, m1_rdata_d;

    // Arbitration: m1 wins when alone or once its denial run has reached the limit.
    always_comb begin
        sel_s = SEL_NONE;
        if (rst) begin
            sel_s = SEL_NONE;
        end else if (m1_req_i && (!m0_req_i || (starve_cnt_q == LIMIT_C))) begin
            sel_s = SEL_M1;
        end else if (m0_req_i) begin
            sel_s = SEL_M0;
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Granted-path mux; with no grant the memory still sees the m0 address.
    always_comb begin
        sel_we_s    = m0_we_i;
        sel_wdata_s = m0_wdata_i;
        sel_be_s    = m0_be_i;
        mem_addr_o  = m0_addr_i;
        case (sel_s)
            SEL_M1: begin
                sel_we_s    = m1_we_i;
                sel_wdata_s = m1_wdata_i;
                sel_be_s    = m1_be_i;
                mem_addr_o  = m1_addr_i;
            end
            default: begin
                sel_we_s    = m0_we_i;
                sel_wdata_s = m0_wdata_i;
                sel_be_s    = m0_be_i;
                mem_addr_o  = m0_addr_i;
            end
        endcase
        m0_gnt_o    = (sel_s == SEL_M0);
        m1_gnt_o    = (sel_s == SEL_M1);
        mem_wr_en_o = (sel_s != SEL_NONE) && sel_we_s && (sel_be_s != 4'b0000);
    end

    data_mem_arbiter_be_merge #(
        .DW(DW)
    ) u_be_merge (
        .old_i    (mem_data_i),
        .new_i    (sel_wdata_s),
        .be_i     (sel_be_s),
        .merged_o (mem_data_o)
    );

    // Starvation counter and response capture; rdata only changes on an accept.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m1_req_i || (sel_s == SEL_M1)) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end

        m0_rvalid_d = (sel_s == SEL_M0);
        m1_rvalid_d = (sel_s == SEL_M1);
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        if (sel_s == SEL_M0) begin
            m0_rdata_d = m0_we_i ? '0 : mem_data_i;
        end else begin
            m0_rdata_d = m0_rdata_q;
        end
        if (sel_s == SEL_M1) begin
            m1_rdata_d = m1_we_i ? '0 : mem_data_i;
        end else begin
            m1_rdata_d = m1_rdata_q;
        end
    end

    // State registers; reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            m0_rvalid_q  <= m0_rvalid_d;
            m1_rvalid_q  <= m1_rvalid_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign m0_rvalid_o = m0_rvalid_q;
    assign m1_rvalid_o = m1_rvalid_q;
    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a behavioural model predicts grants and responses,
// a separate monitor pops expected responses when the DUT should present them.
module tb_data_mem_arbiter;

    localparam int DW    = 32;
    localparam int LIMIT = 3;
    localparam int NW    = 64;

    logic clk = 1'b0;
    logic rst;

    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]    m0_be;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]    m1_be;

    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic          mem_we;

    logic [DW-1:0] mem     [NW];
    logic [DW-1:0] ref_mem [NW];

    logic          load_en;
    int            load_idx;
    logic [DW-1:0] load_val;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int run   = 0;
    logic [DW-1:0] last0 = '0;
    logic [DW-1:0] last1 = '0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0_req_i    (m0_req),
        .m0_we_i     (m0_we),
        .m0_addr_i   (m0_addr),
        .m0_wdata_i  (m0_wdata),
        .m0_be_i     (m0_be),
        .m0_gnt_o    (m0_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m1_req_i    (m1_req),
        .m1_we_i     (m1_we),
        .m1_addr_i   (m1_addr),
        .m1_wdata_i  (m1_wdata),
        .m1_be_i     (m1_be),
        .m1_gnt_o    (m1_gnt),
        .m1_rvalid_o (m1_rvalid),
        .m1_rdata_o  (m1_rdata),
        .mem_addr_o  (mem_addr),
        .mem_wr_en_o (mem_we),
        .mem_data_o  (mem_wdata),
        .mem_data_i  (mem_rdata)
    );

    // Behavioural data_mem: combinational read, clocked word write, preload port for setup.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (load_en) mem[load_idx] <= load_val;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input int m, input logic we, input logic [DW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [3:0] be);
        exp_t e;
        int idx;
        idx   = int'(addr[7:2]);
        e.cyc = cyc + 1;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
            e.data = '0;
        end else begin
            e.data = ref_mem[idx];
        end
        if (m == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Reference model: predicts grants from priority plus a count of consecutive m1 denials.
    always @(negedge clk) begin
        logic exp_g0, exp_g1;
        if (rst) begin
            if (load_en) ref_mem[load_idx] = load_val;
            check_bit("gnt0_in_reset", m0_gnt, 1'b0);
            check_bit("gnt1_in_reset", m1_gnt, 1'b0);
            q0.delete();
            q1.delete();
            run = 0;
        end else begin
            exp_g1 = m1_req && (!m0_req || run >= LIMIT);
            exp_g0 = m0_req && !exp_g1;
            check_bit("m0_gnt", m0_gnt, exp_g0);
            check_bit("m1_gnt", m1_gnt, exp_g1);
            if (exp_g0) model_accept(0, m0_we, m0_addr, m0_wdata, m0_be);
            if (exp_g1) model_accept(1, m1_we, m1_addr, m1_wdata, m1_be);
            if (m1_req && !exp_g1) run = (run < LIMIT) ? run + 1 : run;
            else run = 0;
        end
    end

    // Monitor: a response must appear exactly when due, otherwise rvalid low and rdata held.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check_bit("m0_rvalid_rst", m0_rvalid, 1'b0);
            check_bit("m1_rvalid_rst", m1_rvalid, 1'b0);
            check_word("m0_rdata_rst", m0_rdata, '0);
            check_word("m1_rdata_rst", m1_rdata, '0);
            last0 = '0;
            last1 = '0;
        end else begin
            if (q0.size() > 0 && q0[0].cyc == cyc) begin
                e = q0.pop_front();
                check_bit("m0_rvalid", m0_rvalid, 1'b1);
                check_word("m0_rdata", m0_rdata, e.data);
                last0 = e.data;
            end else begin
                check_bit("m0_rvalid_idle", m0_rvalid, 1'b0);
                check_word("m0_rdata_hold", m0_rdata, last0);
            end
            if (q1.size() > 0 && q1[0].cyc == cyc) begin
                e = q1.pop_front();
                check_bit("m1_rvalid", m1_rvalid, 1'b1);
                check_word("m1_rdata", m1_rdata, e.data);
                last1 = e.data;
            end else begin
                check_bit("m1_rvalid_idle", m1_rvalid, 1'b0);
                check_word("m1_rdata_hold", m1_rdata, last1);
            end
        end
    end

    task automatic idle(input int n);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single transfer on one master; returns one tick after the accepting edge.
    task automatic do_xfer(input int m, input logic we, input logic [DW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [3:0] be);
        bit got;
        got = 1'b0;
        if (m == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (m == 0) ? m0_gnt : m1_gnt;
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL xfer_timeout: got no grant expected grant within 20 cycles (master %0d)", m);
        end
        @(posedge clk);
        #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    initial begin
        bit g0, g1;
        rst = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_be = 4'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_be = 4'h0;
        load_en = 1'b0; load_idx = 0; load_val = '0;
        #2 rst = 1'b1;

        for (int i = 0; i < NW; i++) begin
            @(posedge clk);
            #1;
            load_en  = 1'b1;
            load_idx = i;
            case (i)
                4:       load_val = 32'hDEADBEEF;
                8:       load_val = 32'h11223344;
                12:      load_val = 32'h00000055;
                default: load_val = $urandom;
            endcase
        end
        @(posedge clk);
        #1 load_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // m0 read of 0x10
        do_xfer(0, 1'b0, 32'h10, '0, 4'hF);
        check_bit("t1_m0_rvalid", m0_rvalid, 1'b1);
        check_word("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
        check_bit("t1_m1_rvalid", m1_rvalid, 1'b0);

        // m1 sub-word store
        do_xfer(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
        check_bit("t2_m1_rvalid", m1_rvalid, 1'b1);
        check_word("t2_m1_rdata", m1_rdata, 32'h0);
        check_word("t2_mem_word", mem[8], 32'h11BB33DD);
        idle(2);

        // Both masters requesting continuously
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40; m0_be = 4'hF;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h44; m1_be = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_bit("starve_m0_gnt", m0_gnt, (k % 4) != 3);
            check_bit("starve_m1_gnt", m1_gnt, (k % 4) == 3);
        end
        @(posedge clk);
        #1 idle(2);

        // m1 alone, then m0 joins: m1 must not have built up a denial count
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h48; m1_be = 4'hF;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_bit("solo_m1_gnt", m1_gnt, 1'b1);
        end
        @(posedge clk);
        #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4C; m0_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_bit("join_m0_gnt", m0_gnt, k != 3);
        end
        @(posedge clk);
        #1 idle(2);

        // be = 0 store leaves memory untouched but still responds
        do_xfer(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0);
        check_bit("t5_m0_rvalid", m0_rvalid, 1'b1);
        check_word("t5_mem_word", mem[12], 32'h00000055);
        idle(2);

        // Randomized traffic honouring hold-until-grant
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            g0 = m0_gnt;
            g1 = m1_gnt;
            @(posedge clk);
            #1;
            if (!m0_req || g0) begin
                m0_req   = ($urandom_range(0, 3) != 0);
                m0_we    = 1'($urandom_range(0, 1));
                m0_addr  = 32'($urandom_range(0, 255));
                m0_wdata = $urandom;
                m0_be    = 4'($urandom_range(0, 15));
            end
            if (!m1_req || g1) begin
                m1_req   = ($urandom_range(0, 3) != 0);
                m1_we    = 1'($urandom_range(0, 1));
                m1_addr  = 32'($urandom_range(0, 255));
                m1_wdata = $urandom;
                m1_be    = 4'($urandom_range(0, 15));
            end
        end
        idle(3);

        // Reset lands while an m1 read response is on the outputs
        do_xfer(1, 1'b0, 32'h10, '0, 4'hF);
        check_bit("t6_m1_rvalid_pre", m1_rvalid, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("t6_m1_rvalid_rst", m1_rvalid, 1'b0);
        check_word("t6_m1_rdata_rst", m1_rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);

        check_word("q0_drained", 32'(q0.size()), 32'h0);
        check_word("q1_drained", 32'(q1.size()), 32'h0);
        for (int i = 0; i < NW; i++) begin
            check_word("mem_final", mem[i], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between two requesters: m0 = core load/store unit (high priority) and m1 = debug/DMA port (low priority, starvation-protected).
- The memory reads combinationally and writes on the clock edge, word-wide only. This block adds:
  - byte-enable merging for sub-word stores;
  - a registered one-cycle response path.
- Sits between the core/debug masters and data_mem.

Parameters:
- DW, 32, data/address width (equals `CPU_WIDTH`).
- STARVE_LIMIT, 3, consecutive denied cycles of m1 before m1 is forced a grant; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- m0_req_i  in  1  m0 request
- m0_we_i  in  1  m0 write (1) / read (0)
- m0_addr_i  in  DW  m0 byte address, word-aligned use of [DW-1:2]
- m0_wdata_i  in  DW  m0 store data, lane-aligned
- m0_be_i  in  4  m0 byte enables
- m0_gnt_o  out  1  m0 accepted this cycle (combinational)
- m0_rvalid_o  out  1  m0 response valid
- m0_rdata_o  out  DW  m0 read data
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_be_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o: same as m0, for m1
- mem_addr_o  out  DW  to data_mem address
- mem_wr_en_o  out  1  to data_mem write enable
- mem_data_o  out  DW  to data_mem write data (merged word)
- mem_data_i  in  DW  from data_mem combinational read word

Behaviour:
- Handshake: a transfer is accepted in the cycle where req & gnt = 1. A master holds req, we, addr, wdata and be stable until gnt.
- At most one gnt per cycle. gnt is 0 while rst = 1.
- Arbitration:
  - Only one master requesting: that master is granted.
  - Both requesting: m0 wins, unless starve_cnt == STARVE_LIMIT, in which case m1 wins.
- starve_cnt (4-bit register):
  - increments when m1_req & !m1_gnt;
  - clears to 0 on any m1 grant or when m1_req = 0;
  - saturates at STARVE_LIMIT.
- Memory drive:
  - mem_addr_o = address of the granted master; with no grant it is the m0 address.
  - mem_wr_en_o = gnt & we & (be != 0).
- Write merge: per lane i, mem_data_o byte i = be[i] ? wdata byte i : mem_data_i byte i. The read and write of the same word complete in one cycle.
- be = 0 write: accepted, no memory change, response still returned.
- Read merge: be is ignored; the full word is returned. Sign/zero extension is the LSU's job.
- Response:
  - The granted master's rvalid pulses exactly 1 cycle after accept, for one cycle.
  - rdata is registered: the mem_data_i word for reads, 0 for writes.
  - rdata holds its value when rvalid = 0.
- Back-to-back accepts from the same master are allowed every cycle. Throughput is 1 transfer/cycle total.
- Reset (asynchronous, any time, including while a response is pending):
  - rvalid = 0, rdata = 0, starve_cnt = 0, mem_wr_en_o = 0.
  - The pending response is dropped and no write occurs while rst = 1.
  - Operation resumes on the first clk edge after rst falls.
- Address bits [1:0] are ignored. Out-of-range address bits are truncated by data_mem.

Decomposition:
- Shared defines: `CPU_WIDTH`, byte-enable width (4), the DATA_MEM address-width macros (already in rooth_defines.v).
- One sub-module: be_merge (combinational lane merge of old word, new word and be). Instantiated once, on the granted path.
- Arbitration, starvation counter and response registers stay in the top.

Test Plan:
- Reset then m0 reads addr 0x10 holding 0xDEADBEEF:
  - m0_gnt = 1 in cycle 0;
  - cycle 1: m0_rvalid = 1, m0_rdata = 0xDEADBEEF;
  - m1 signals stay 0.
- Word 0x20 = 0x11223344; m1 writes wdata 0xAABBCCDD with be = 4'b0101:
  - word becomes 0x11BB33DD;
  - m1_rvalid pulses one cycle later with rdata 0.
- m0 and m1 both request continuously, STARVE_LIMIT = 3:
  - grants follow m0, m0, m0, m1, m0, m0, m0, m1, …;
  - each rvalid lands on the correct master 1 cycle after its grant.
- Only m1 requests for 5 cycles: m1_gnt = 1 every cycle, starve_cnt stays 0.
- m0 writes with be = 0 to addr 0x30 (value 0x55):
  - memory is unchanged at 0x55;
  - m0_rvalid = 1 next cycle.
- Assert rst in the cycle after an m1 read accept:
  - m1_rvalid = 0 and m1_rdata = 0 immediately;
  - no spurious rvalid after rst is released.
